fetch_queue: RTL and testbench

Instruction-fetch stage that sits directly upstream of decode and the immediate extender. It issues in-order word fetches to instruction memory and buffers the returned words in a DEPTH-entry FIFO, each tagged with its PC. It presents one instruction per cycle to decode with a valid/ready handshake. On a branch or jump redirect it flushes the FIFO and discards all in-flight responses.

---
 rtl/fetch_queue_if.sv | 49 ++++
 rtl/fetch_queue.sv | 116 +++++++++++
 tb/tb_fetch_queue.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-stage bus bundle: instruction-memory request/response plus the
// decode-side handshake and redirect inputs.
interface fetch_queue_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        id_ready;
   logic        id_valid;
   logic [31:0] id_inst;
   logic [24:0] id_imm_field;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata,
      input  redirect,
      input  redirect_pc,
      input  id_ready,
      output id_valid,
      output id_inst,
      output id_imm_field,
      output id_pc,
      output id_pc_plus4
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata,
      output redirect,
      output redirect_pc,
      output id_ready,
      input  id_valid,
      input  id_inst,
      input  id_imm_field,
      input  id_pc,
      input  id_pc_plus4
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch stage: in-order word fetch into a PC-tagged FIFO,
// with redirect flush and discard of in-flight responses.
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic           clk,
   input logic           rst_n,
   fetch_queue_if.master io_bus
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int LW = CW + 1;

   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_resp_pc;
   logic [31:0]   r_inst [DEPTH];
   logic [31:0]   r_pc   [DEPTH];
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;
   logic [CW-1:0] r_outst;
   logic [CW-1:0] r_drop;

   logic [LW-1:0] w_level;
   logic          w_req;
   logic          w_grant;
   logic          w_drop_any;
   logic          w_discard;
   logic          w_push;
   logic          w_valid;
   logic          w_pop;
   logic [CW-1:0] w_drop_redir;
   logic [31:0]   w_head_inst;
   logic [31:0]   w_head_pc;

   // Entries, live requests and pending discards share one DEPTH budget,
   // so an accepted response always has a free slot.
   assign w_level = LW'(r_count) + LW'(r_outst) + LW'(r_drop);
   assign w_req   = rst_n & ~io_bus.redirect
                  & (w_level < LW'(DEPTH));
   assign w_grant = w_req & io_bus.imem_gnt;

   assign w_drop_any = (r_drop != '0);
   assign w_discard  = io_bus.imem_rvalid
                     & (io_bus.redirect | w_drop_any);
   assign w_push     = io_bus.imem_rvalid & ~w_discard;

   assign w_valid = (r_count != '0) & ~io_bus.redirect;
   assign w_pop   = w_valid & io_bus.id_ready;

   // Everything still in flight at a redirect becomes a discard.
   assign w_drop_redir = CW'(LW'(r_drop) + LW'(r_outst)
                       - LW'(io_bus.imem_rvalid));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_pc <= RESET_PC;
         r_resp_pc  <= RESET_PC;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_outst    <= '0;
         r_drop     <= '0;
      end else if (io_bus.redirect) begin
         r_fetch_pc <= io_bus.redirect_pc;
         r_resp_pc  <= io_bus.redirect_pc;
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_outst    <= '0;
         r_drop     <= w_drop_redir;
      end else begin
         if (w_grant) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
         end
         if (w_push) begin
            r_resp_pc <= r_resp_pc + 32'd4;
            r_wr_ptr  <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
         r_outst <= r_outst + CW'(w_grant) - CW'(w_push);
         if (io_bus.imem_rvalid && w_drop_any) begin
            r_drop <= r_drop - CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_inst[i] <= '0;
            r_pc[i]   <= '0;
         end
      end else if (w_push) begin
         r_inst[r_wr_ptr] <= io_bus.imem_rdata;
         r_pc[r_wr_ptr]   <= r_resp_pc;
      end
   end

   assign w_head_inst = r_inst[r_rd_ptr];
   assign w_head_pc   = r_pc[r_rd_ptr];

   assign io_bus.imem_req     = w_req;
   assign io_bus.imem_addr    = r_fetch_pc;
   assign io_bus.id_valid     = w_valid;
   assign io_bus.id_inst      = w_head_inst;
   assign io_bus.id_imm_field = w_head_inst[31:7];
   assign io_bus.id_pc        = w_head_pc;
   assign io_bus.id_pc_plus4  = w_head_pc + 32'd4;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized scoreboard bench for fetch_queue with a latency-varying
// in-order memory model and a sequential-PC reference stream.
module tb_fetch_queue;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic clk;
   logic rst_n;

   fetch_queue_if bus();

   fetch_queue #(
      .DEPTH    (4),
      .RESET_PC (RST_PC)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   pend_t       pend[$];
   logic [31:0] exp_q[$];
   logic [31:0] exp_next;
   int          cyc;
   int          lat;
   int          checks;
   int          failures;
   int          delivered;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ {a[15:0], 16'h5A3C} ^ 32'h1357_0000;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic topup();
      while (exp_q.size() < 16) begin
         exp_q.push_back(exp_next);
         exp_next = exp_next + 32'd4;
      end
   endtask

   task automatic set_stream(input logic [31:0] pc);
      exp_q.delete();
      exp_next = pc;
      topup();
   endtask

   task automatic step();
      @(posedge clk);
      #2;
      topup();
   endtask

   task automatic do_redirect(input logic [31:0] pc);
      bus.redirect    = 1'b1;
      bus.redirect_pc = pc;
      set_stream(pc);
      step();
      bus.redirect = 1'b0;
   endtask

   task automatic wait_valid(input string nm, input logic [31:0] pc);
      bit seen;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (bus.id_valid) begin
            seen = 1;
            chk(nm, bus.id_pc, pc);
         end
      end
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout actual=no_valid required=valid", nm);
      end
   endtask

   // Memory: drives responses in order, each no earlier than its due cycle.
   initial begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (rst_n && pend.size() > 0 && pend[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem(pend[0].addr);
         end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = $urandom;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pend.delete();
         end else begin
            if (bus.imem_rvalid && pend.size() > 0)
               void'(pend.pop_front());
            if (bus.imem_req && bus.imem_gnt)
               pend.push_back('{addr: bus.imem_addr, due: cyc + lat});
         end
      end
   end

   // Monitor: pops one expectation per accepted instruction.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.redirect)
               chk("valid_in_redirect", {31'd0, bus.id_valid}, 32'd0);
            if (bus.imem_req)
               chk("addr_align", {30'd0, bus.imem_addr[1:0]}, 32'd0);
            if (bus.id_valid && bus.id_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL sb_empty actual=%h required=none",
                           bus.id_pc);
               end else begin
                  e = exp_q.pop_front();
                  delivered++;
                  chk("id_pc", bus.id_pc, e);
                  chk("id_inst", bus.id_inst, mem(e));
                  chk("id_pc_plus4", bus.id_pc_plus4, e + 32'd4);
                  chk("id_imm", {7'd0, bus.id_imm_field}, {7'd0, mem(e) >> 7});
               end
            end
         end
      end
   end

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_req"},   {31'd0, bus.imem_req}, 32'd0);
      chk({nm, "_valid"}, {31'd0, bus.id_valid}, 32'd0);
      chk({nm, "_addr"},  bus.imem_addr, RST_PC);
      chk({nm, "_inst"},  bus.id_inst, 32'd0);
      chk({nm, "_pc"},    bus.id_pc, 32'd0);
   endtask

   initial begin
      int d0;
      checks          = 0;
      failures        = 0;
      delivered       = 0;
      lat             = 1;
      rst_n           = 1'b0;
      bus.imem_gnt    = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      bus.id_ready    = 1'b0;
      set_stream(RST_PC);
      repeat (3) step();
      chk_reset_outputs("rst");

      // Fill latency and throughput out of reset
      bus.imem_gnt = 1'b1;
      bus.id_ready = 1'b1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("t1_req", {31'd0, bus.imem_req}, 32'd1);
      chk("t1_addr0", bus.imem_addr, RST_PC);
      chk("t1_v1", {31'd0, bus.id_valid}, 32'd0);
      @(negedge clk);
      chk("t1_v2", {31'd0, bus.id_valid}, 32'd0);
      @(negedge clk);
      chk("t1_v3", {31'd0, bus.id_valid}, 32'd1);
      chk("t1_pc", bus.id_pc, RST_PC);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("t1_stream", {31'd0, bus.id_valid}, 32'd1);
      end

      // Back-pressure: exactly DEPTH entries then drain in order
      step();
      bus.id_ready = 1'b0;
      do_redirect(32'h0);
      repeat (10) step();
      @(negedge clk);
      chk("t2_req_off", {31'd0, bus.imem_req}, 32'd0);
      chk("t2_head", bus.id_pc, 32'h0);
      step();
      d0 = delivered;
      bus.id_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t2_drain_v", {31'd0, bus.id_valid}, 32'd1);
         chk("t2_drain_pc", bus.id_pc, 32'(i * 4));
      end
      step();
      chk("t2_count", 32'(delivered - d0), 32'd4);

      // Redirect with long-latency requests in flight
      lat = 3;
      repeat (6) step();
      do_redirect(32'h100);
      wait_valid("t3_first", 32'h100);

      // Redirect on an rvalid cycle, then a second redirect
      lat = 2;
      repeat (4) step();
      for (int i = 0; i < 20 && !bus.imem_rvalid; i++) step();
      do_redirect(32'h180);
      step();
      do_redirect(32'h200);
      wait_valid("t4_first", 32'h200);

      // PC wrap
      lat = 1;
      repeat (3) step();
      d0 = delivered;
      do_redirect(32'hFFFF_FFF8);
      repeat (10) step();
      chk("t5_progress", {31'd0, (delivered - d0) >= 4}, 32'd1);

      // Async reset with entries buffered
      bus.id_ready = 1'b0;
      do_redirect(32'h40);
      repeat (4) step();
      @(negedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("t6");
      set_stream(RST_PC);
      repeat (2) step();
      bus.id_ready = 1'b1;
      rst_n = 1'b1;
      wait_valid("t6_restart", RST_PC);

      // Randomized traffic
      d0 = delivered;
      for (int n = 0; n < 3000; n++) begin
         bus.imem_gnt = ($urandom_range(3) != 0);
         bus.id_ready = ($urandom_range(2) != 0);
         lat = 1 + $urandom_range(3);
         if ($urandom_range(29) == 0) begin
            if ($urandom_range(3) == 0)
               do_redirect(32'hFFFF_FFF0 + {$urandom_range(3), 2'b00});
            else
               do_redirect({$urandom, 2'b00} >> 0 & 32'hFFFF_FFFC);
            if ($urandom_range(3) == 0)
               do_redirect({$urandom_range(1023), 2'b00});
         end else begin
            step();
         end
      end
      chk("rand_progress", {31'd0, (delivered - d0) > 300}, 32'd1);

      bus.id_ready = 1'b0;
      repeat (3) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
